// File: rtl/fsk_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fsk_window_sequencer
//  Purpose  : Runs one frequency_analyzer in fixed measurement windows
//             (clear -> measure -> settle -> capture). Decides one FSK symbol
//             per window from the latched f0/f1 accumulations and offers it
//             downstream on a valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock             in   system clock, rising edge
//    clear             in   synchronous reset, active-high
//    run               in   1 = keep measuring windows back to back
//    analyzer_clear_n  out  analyzer clear (active-low), low only in CLEAR
//    analyzer_enable   out  analyzer enable, high only in MEASURE
//    f0_value          in   analyzer f0 accumulation
//    f1_value          in   analyzer f1 accumulation
//    symbol_valid      out  result available
//    symbol_ready      in   downstream accepts result
//    symbol_bit        out  decided bit
//    symbol_error      out  no valid decision for this window
//    symbol_f0         out  latched f0_value
//    symbol_f1         out  latched f1_value
//    overrun           out  sticky: a result was replaced before acceptance
//    busy              out  sequencer is not idle
//    window_count      out  completed windows, wraps 0xFFFF -> 0
// ============================================================================
module fsk_window_sequencer #(
   parameter int unsigned WINDOW_TICKS = 50000,
   parameter int unsigned SETTLE_TICKS = 2,
   parameter int unsigned MIN_COUNT    = 1000
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   output logic        analyzer_clear_n,
   output logic        analyzer_enable,
   input  logic [31:0] f0_value,
   input  logic [31:0] f1_value,
   output logic        symbol_valid,
   input  logic        symbol_ready,
   output logic        symbol_bit,
   output logic        symbol_error,
   output logic [31:0] symbol_f0,
   output logic [31:0] symbol_f1,
   output logic        overrun,
   output logic        busy,
   output logic [15:0] window_count
);

   // One shared tick counter serves both the MEASURE and SETTLE phases, so
   // it is sized for the longer of the two.
   localparam int unsigned c_max_ticks = (WINDOW_TICKS > SETTLE_TICKS) ? WINDOW_TICKS : SETTLE_TICKS;
   localparam int          c_cnt_w     = (c_max_ticks > 1) ? $clog2(c_max_ticks) : 1;

   localparam logic [c_cnt_w-1:0] c_win_last = c_cnt_w'(WINDOW_TICKS - 1);
   localparam logic [c_cnt_w-1:0] c_set_last = c_cnt_w'(SETTLE_TICKS - 1);
   localparam logic [c_cnt_w-1:0] c_tick_one = c_cnt_w'(1);
   localparam logic [31:0]        c_min      = 32'(MIN_COUNT);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_MEASURE = 3'd2,
      S_SETTLE  = 3'd3,
      S_CAPTURE = 3'd4
   } state_t;

   state_t             r_state;
   logic [c_cnt_w-1:0] r_tick;
   logic               r_valid;
   logic               r_bit;
   logic               r_error;
   logic [31:0]        r_f0;
   logic [31:0]        r_f1;
   logic               r_overrun;
   logic [15:0]        r_window_count;

   // Decision from the live analyzer values; only sampled at the CAPTURE edge.
   logic w_f1_wins;
   logic w_f0_wins;
   logic w_capture;
   logic w_accept;

   assign w_f1_wins = (f1_value > f0_value) && (f1_value >= c_min);
   assign w_f0_wins = (f0_value > f1_value) && (f0_value >= c_min);
   assign w_capture = (r_state == S_CAPTURE);
   assign w_accept  = r_valid && symbol_ready;

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state        <= S_IDLE;
         r_tick         <= '0;
         r_valid        <= 1'b0;
         r_bit          <= 1'b0;
         r_error        <= 1'b0;
         r_f0           <= '0;
         r_f1           <= '0;
         r_overrun      <= 1'b0;
         r_window_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_state <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               r_tick  <= '0;
               r_state <= S_MEASURE;
            end
            // run is deliberately ignored here: a started window always finishes.
            S_MEASURE: begin
               if (r_tick == c_win_last) begin
                  r_tick  <= '0;
                  r_state <= S_SETTLE;
               end else begin
                  r_tick <= r_tick + c_tick_one;
               end
            end
            // Gives the analyzer's registered check pipeline time to flush
            // its last enabled cycle into the accumulators.
            S_SETTLE: begin
               if (r_tick == c_set_last) begin
                  r_tick  <= '0;
                  r_state <= S_CAPTURE;
               end else begin
                  r_tick <= r_tick + c_tick_one;
               end
            end
            S_CAPTURE: begin
               r_window_count <= r_window_count + 16'd1;
               r_state        <= run ? S_CLEAR : S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_tick  <= '0;
            end
         endcase

         // Result register. A capture always wins over a pending handshake;
         // it is only an overrun if the old result was not being accepted on
         // this same edge.
         if (w_capture) begin
            r_f0    <= f0_value;
            r_f1    <= f1_value;
            r_bit   <= w_f1_wins;
            r_error <= !(w_f1_wins || w_f0_wins);
            r_valid <= 1'b1;
            if (r_valid && !symbol_ready) begin
               r_overrun <= 1'b1;
            end
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign analyzer_clear_n = (r_state != S_CLEAR);
   assign analyzer_enable  = (r_state == S_MEASURE);
   assign busy             = (r_state != S_IDLE);
   assign symbol_valid     = r_valid;
   assign symbol_bit       = r_bit;
   assign symbol_error     = r_error;
   assign symbol_f0        = r_f0;
   assign symbol_f1        = r_f1;
   assign overrun          = r_overrun;
   assign window_count     = r_window_count;

endmodule
`default_nettype wire

// File: tb/tb_fsk_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsk_window_sequencer
//  Purpose  : Directed self-checking bench for fsk_window_sequencer with
//             WINDOW_TICKS=8, SETTLE_TICKS=2, MIN_COUNT=3 (window period 12).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsk_window_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic        run;
   logic        analyzer_clear_n;
   logic        analyzer_enable;
   logic [31:0] f0_value;
   logic [31:0] f1_value;
   logic        symbol_valid;
   logic        symbol_ready;
   logic        symbol_bit;
   logic        symbol_error;
   logic [31:0] symbol_f0;
   logic [31:0] symbol_f1;
   logic        overrun;
   logic        busy;
   logic [15:0] window_count;

   int vectors     = 0;
   int miscompares = 0;

   fsk_window_sequencer #(
      .WINDOW_TICKS (8),
      .SETTLE_TICKS (2),
      .MIN_COUNT    (3)
   ) dut (
      .clock            (clock),
      .clear            (clear),
      .run              (run),
      .analyzer_clear_n (analyzer_clear_n),
      .analyzer_enable  (analyzer_enable),
      .f0_value         (f0_value),
      .f1_value         (f1_value),
      .symbol_valid     (symbol_valid),
      .symbol_ready     (symbol_ready),
      .symbol_bit       (symbol_bit),
      .symbol_error     (symbol_error),
      .symbol_f0        (symbol_f0),
      .symbol_f1        (symbol_f1),
      .overrun          (overrun),
      .busy             (busy),
      .window_count     (window_count)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      clear = 1'b1;
      step(2);
      clear = 1'b0;
   endtask

   // Single window from IDLE. lat = cycles from CLEAR entry until valid;
   // n_clr / n_en = cycles with analyzer clear low / enable high before valid.
   task automatic run_window(input logic [31:0] a0, input logic [31:0] a1,
                             output int lat, output int n_clr, output int n_en);
      f0_value = a0;
      f1_value = a1;
      run      = 1'b1;
      tick();
      run   = 1'b0;
      lat   = 0;
      n_clr = 0;
      n_en  = 0;
      while (symbol_valid !== 1'b1 && lat < 30) begin
         if (analyzer_clear_n === 1'b0) n_clr++;
         if (analyzer_enable === 1'b1) n_en++;
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat, n_clr, n_en;
      int pos[3];
      int nclr;
      int nvalid, nbusy;

      clear        = 1'b1;
      run          = 1'b0;
      symbol_ready = 1'b1;
      f0_value     = '0;
      f1_value     = '0;
      do_reset();

      // Reset state
      check("rst_busy",     32'(busy),             32'd0);
      check("rst_clear_n",  32'(analyzer_clear_n), 32'd1);
      check("rst_enable",   32'(analyzer_enable),  32'd0);
      check("rst_valid",    32'(symbol_valid),     32'd0);
      check("rst_overrun",  32'(overrun),          32'd0);
      check("rst_count",    32'(window_count),     32'd0);
      check("rst_f0",       symbol_f0,             32'd0);
      check("rst_bit",      32'(symbol_bit),       32'd0);

      // One window, f1 wins
      run_window(32'd2, 32'd6, lat, n_clr, n_en);
      check("w1_latency",   32'(lat),              32'd12);
      check("w1_clr_cyc",   32'(n_clr),            32'd1);
      check("w1_en_cyc",    32'(n_en),             32'd8);
      check("w1_bit",       32'(symbol_bit),       32'd1);
      check("w1_error",     32'(symbol_error),     32'd0);
      check("w1_f1",        symbol_f1,             32'd6);
      check("w1_f0",        symbol_f0,             32'd2);
      check("w1_count",     32'(window_count),     32'd1);
      check("w1_idle",      32'(busy),             32'd0);
      tick();
      check("w1_valid_drop", 32'(symbol_valid),    32'd0);

      // Tie
      run_window(32'd5, 32'd5, lat, n_clr, n_en);
      check("tie_latency",  32'(lat),              32'd12);
      check("tie_error",    32'(symbol_error),     32'd1);
      check("tie_bit",      32'(symbol_bit),       32'd0);
      tick();

      // f0 larger but below MIN_COUNT
      run_window(32'd2, 32'd1, lat, n_clr, n_en);
      check("low_error",    32'(symbol_error),     32'd1);
      check("low_bit",      32'(symbol_bit),       32'd0);
      tick();

      // f1 exactly at MIN_COUNT
      run_window(32'd0, 32'd3, lat, n_clr, n_en);
      check("min_bit",      32'(symbol_bit),       32'd1);
      check("min_error",    32'(symbol_error),     32'd0);
      tick();

      // f0 wins
      run_window(32'd4, 32'd3, lat, n_clr, n_en);
      check("f0_bit",       32'(symbol_bit),       32'd0);
      check("f0_error",     32'(symbol_error),     32'd0);
      check("f0_count",     32'(window_count),     32'd5);
      tick();

      // Continuous run, three windows
      do_reset();
      symbol_ready = 1'b1;
      f0_value     = 32'd9;
      f1_value     = 32'd1;
      run          = 1'b1;
      nclr         = 0;
      pos          = '{0, 0, 0};
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (analyzer_clear_n === 1'b0) begin
            if (nclr < 3) pos[nclr] = k;
            nclr++;
            if (nclr == 3) run = 1'b0;
         end
         if (nclr >= 3 && busy === 1'b0) break;
      end
      check("cont_clears",  32'(nclr),             32'd3);
      check("cont_gap1",    32'(pos[1] - pos[0]),  32'd12);
      check("cont_gap2",    32'(pos[2] - pos[1]),  32'd12);
      check("cont_count",   32'(window_count),     32'd3);
      check("cont_overrun", 32'(overrun),          32'd0);
      check("cont_bit",     32'(symbol_bit),       32'd0);

      // Capture coinciding with handshake: no overrun
      do_reset();
      symbol_ready = 1'b0;
      f0_value     = 32'd2;
      f1_value     = 32'd6;
      run          = 1'b1;
      tick();                         // CLEAR
      step(12);                       // first result loaded
      check("hs_valid1",    32'(symbol_valid),     32'd1);
      check("hs_bit1",      32'(symbol_bit),       32'd1);
      f0_value = 32'd8;
      f1_value = 32'd0;
      step(11);                       // second CAPTURE
      symbol_ready = 1'b1;
      run          = 1'b0;
      tick();
      check("hs_valid2",    32'(symbol_valid),     32'd1);
      check("hs_bit2",      32'(symbol_bit),       32'd0);
      check("hs_f0",        symbol_f0,             32'd8);
      check("hs_overrun",   32'(overrun),          32'd0);
      check("hs_count",     32'(window_count),     32'd2);
      tick();
      check("hs_drop",      32'(symbol_valid),     32'd0);

      // Overrun: two captures with ready low, then handshake on a capture edge
      do_reset();
      symbol_ready = 1'b0;
      f0_value     = 32'd2;
      f1_value     = 32'd6;
      run          = 1'b1;
      tick();
      step(12);
      f0_value = 32'd7;
      f1_value = 32'd1;
      step(12);
      check("ov_valid",     32'(symbol_valid),     32'd1);
      check("ov_bit",       32'(symbol_bit),       32'd0);
      check("ov_f0",        symbol_f0,             32'd7);
      check("ov_flag",      32'(overrun),          32'd1);
      f0_value = 32'd5;
      f1_value = 32'd5;
      step(11);                       // third CAPTURE
      symbol_ready = 1'b1;
      run          = 1'b0;
      tick();
      check("ov_valid3",    32'(symbol_valid),     32'd1);
      check("ov_error3",    32'(symbol_error),     32'd1);
      check("ov_flag3",     32'(overrun),          32'd1);
      check("ov_count",     32'(window_count),     32'd3);
      tick();
      check("ov_drop",      32'(symbol_valid),     32'd0);
      check("ov_idle",      32'(busy),             32'd0);

      // Reset in the middle of MEASURE (window_count is 3 beforehand)
      run = 1'b1;
      tick();
      run = 1'b0;
      step(4);
      check("ab_enable_pre", 32'(analyzer_enable), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("ab_enable",    32'(analyzer_enable),  32'd0);
      check("ab_clear_n",   32'(analyzer_clear_n), 32'd1);
      check("ab_valid",     32'(symbol_valid),     32'd0);
      check("ab_count",     32'(window_count),     32'd0);
      check("ab_busy",      32'(busy),             32'd0);
      nvalid = 0;
      nbusy  = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (symbol_valid === 1'b1) nvalid++;
         if (busy === 1'b1) nbusy++;
      end
      check("ab_no_symbol", 32'(nvalid),           32'd0);
      check("ab_stay_idle", 32'(nbusy),            32'd0);

      // window_count wrap
      force dut.r_window_count = 16'hFFFF;
      tick();
      release dut.r_window_count;
      check("wrap_preset",  32'(window_count),     32'h0000FFFF);
      run_window(32'd1, 32'd4, lat, n_clr, n_en);
      check("wrap_latency", 32'(lat),              32'd12);
      check("wrap_count",   32'(window_count),     32'd0);
      check("wrap_bit",     32'(symbol_bit),       32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
